aes_round_seq: RTL and testbench
================================

// Module: aes_round_seq
// PURPOSE
// - Sequences one full AES encryption round (SubBytes+ShiftRows+MixColumns+AddRoundKey, x86 AESENC semantics) over a 128-bit state.
// - Uses NUM_PORTS shared external T-table lookup ports instead of 16 private tables.
// - Each table port returns E(x) = {S(x), S(x), 2*S(x), 3*S(x)} (bits 31:24 down to 7:0), i.e. the existing aes_table2 ROM.
// - Sits between the phase-2 scratchpad loop and the table ROMs; the loop hands it state+key and collects the round result.
// PARAMETERS
// - NUM_PORTS  default 1  table ports used per cycle; legal values 1, 2, 4 (elaboration error otherwise).
// PORTS
// - clk         in   1               clock
// - reset       in   1               synchronous reset, active high
// - in_valid    in   1               request valid
// - in_ready    out  1               request accepted when in_valid & in_ready
// - state_i     in   128             input state; byte b = bits [8b+7:8b], row b%4, column b/4
// - key_i       in   128             round key; same layout as state_i
// - tab_idx_o   out  8*NUM_PORTS     lookup index, port p = bits [8p+7:8p]
// - tab_data_i  in   32*NUM_PORTS    E(tab_idx) per port; combinational, same cycle
// - out_valid   out  1               result valid
// - out_ready   in   1               result consumed when out_valid & out_ready
// - state_o     out  128             round result, same layout
// - busy        out  1               high in any state other than IDLE
// BEHAVIOUR
// - Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, tab_idx_o=0, state_o=0, internal counter/accumulators=0.
// - FSM states and transitions:
//   - IDLE -> LOOK on accept; state_i/key_i are registered; accumulators are loaded with key_i.
//   - LOOK -> LOOK: 16/NUM_PORTS cycles; counter cnt counts 0..16/NUM_PORTS-1.
//   - LOOK -> DONE after the last accumulate.
//   - DONE -> IDLE on out_valid & out_ready.
// - Handshake signals:
//   - in_ready = (state==IDLE).
//   - out_valid = (state==DONE).
//   - busy = !IDLE.
//   - in_valid while busy is ignored, not queued.
// - Lookup k (0..15): column c=k/4, row j=k%4, source byte = row j of column (c+j)%4 (ShiftRows).
//   - Issued in LOOK cycle cnt on port p, where k = NUM_PORTS*cnt + p.
// - Accumulate: acc[c] ^= rotl32(E, 8*((j+3)%4)).
//   - j=0 -> rotr8, j=1 -> none, j=2 -> rotl8, j=3 -> rotl16.
//   - acc[c] maps to state_o[32c+31:32c].
// - All XOR is 32-bit; no carries.
// - tab_idx_o is 0 outside LOOK.
// - state_o updates only on entering DONE.
// - state_o is held stable while out_valid & !out_ready.
// - Latency: out_valid rises 16/NUM_PORTS+1 clocks after the accept edge.
//   - NUM_PORTS=1: 17 clocks; NUM_PORTS=4: 5 clocks.
// - Throughput: 1 round per 16/NUM_PORTS+2 clocks; no back-to-back accept from DONE.
// - Boundary conditions:
//   - reset mid-LOOK or in DONE -> IDLE next edge; partial result discarded; out_valid=0.
//   - out_ready held high -> DONE lasts exactly 1 cycle.
//   - in_valid during DONE is not accepted until back in IDLE.
// CONFIGURATION
// - AES_ROUND_SEQ_TABREG_EN defined:
//   - tab_data_i is registered before use, together with delayed copies of its (column, row) tags.
//   - Accumulation lags issue by 1 cycle; LOOK is extended by 1 drain cycle.
//   - Latency becomes 16/NUM_PORTS+2 clocks (18 for NUM_PORTS=1).
//   - Reset also clears the pipeline register and its valid bit.
// - Undefined: combinational path tab_data_i -> accumulator, latency as above.
// TESTING
// - Zero state, zero key, NUM_PORTS=1 -> state_o = {16{8'h63}}, out_valid at clock 17 after accept.
// - Zero state, key all 1s -> state_o = {16{8'h9c}}; repeat with NUM_PORTS=4 -> same value, latency 5.
// - state_i all 8'h52 (S=00, E=0), key = 128'h0f0e..00 -> state_o == key.
// - Known AESENC vector (state 128'h00112233..ff, key 128'h0) -> match golden model.
//   - Also check tab_idx_o sequence = byte indices 0,5,10,15,4,9,14,3,...
// - out_ready low 10 cycles, then toggled -> state_o stable, in_ready=0.
//   - in_valid pulses during busy are ignored.
// - Reset asserted at LOOK cycle 7, then new request -> only the new result appears.
//   - Rerun the full plan with AES_ROUND_SEQ_TABREG_EN defined (latency +1).

Source files
------------

// File: rtl/aes_round_seq.sv
// One AES encryption round (AESENC semantics) sequenced over NUM_PORTS shared T-table ports.
// Define AES_ROUND_SEQ_TABREG_EN to register tab_data_i before accumulation (+1 cycle latency).
module aes_round_seq #(
  parameter int unsigned NUM_PORTS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              state_i,
  input  logic [127:0]              key_i,
  output logic [8*NUM_PORTS-1:0]    tab_idx_o,
  input  logic [32*NUM_PORTS-1:0]   tab_data_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              state_o,
  output logic                      busy
);

  if (NUM_PORTS != 1 && NUM_PORTS != 2 && NUM_PORTS != 4) begin : g_bad_ports
    $error("aes_round_seq: NUM_PORTS must be 1, 2 or 4");
  end

  localparam int unsigned Issue = 16 / NUM_PORTS;
`ifdef AES_ROUND_SEQ_TABREG_EN
  localparam int unsigned LookLen = Issue + 1;
`else
  localparam int unsigned LookLen = Issue;
`endif
  localparam int unsigned CntW = $clog2(LookLen + 1);

  typedef enum logic [1:0] {StIdle, StLook, StDone} fsm_e;

  fsm_e                      fsm_q, fsm_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [127:0]              st_q, st_d;
  logic [127:0]              acc_q, acc_d;
  logic [127:0]              res_q, res_d;

  logic                      issue;
  logic                      last_look;
  logic [NUM_PORTS-1:0][3:0] tag_k;

  logic                      acc_vld;
  logic [32*NUM_PORTS-1:0]   acc_data;
  logic [NUM_PORTS-1:0][3:0] acc_tag;

  // Rotate E(x) = {S,S,2S,3S} so that row j lands in the MixColumns position.
  function automatic logic [31:0] rot_e(input logic [31:0] e, input logic [1:0] j);
    logic [31:0] r;
    case (j)
      2'd0:    r = {e[7:0], e[31:8]};
      2'd1:    r = e;
      2'd2:    r = {e[23:0], e[31:24]};
      default: r = {e[15:0], e[31:16]};
    endcase
    return r;
  endfunction

  // ShiftRows: row j of output column c comes from column (c+j)%4.
  function automatic logic [7:0] shift_src(input logic [127:0] s, input logic [3:0] k);
    logic [1:0] col;
    logic [3:0] pos;
    col = k[3:2] + k[1:0];
    pos = {col, k[1:0]};
    return s[8*pos +: 8];
  endfunction

  always_comb begin
    issue     = (fsm_q == StLook) && (32'(cnt_q) < Issue);
    last_look = (fsm_q == StLook) && (cnt_q == CntW'(LookLen - 1));
    for (int p = 0; p < NUM_PORTS; p++) begin
      tag_k[p] = 4'(NUM_PORTS * 32'(cnt_q) + 32'(p));
    end
  end

`ifdef AES_ROUND_SEQ_TABREG_EN
  logic [32*NUM_PORTS-1:0]   pipe_q;
  logic [NUM_PORTS-1:0][3:0] pipe_tag_q;
  logic                      pipe_vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q     <= '0;
      pipe_tag_q <= '0;
      pipe_vld_q <= 1'b0;
    end else begin
      pipe_q     <= tab_data_i;
      pipe_tag_q <= tag_k;
      pipe_vld_q <= issue;
    end
  end

  always_comb begin
    acc_vld  = pipe_vld_q;
    acc_data = pipe_q;
    acc_tag  = pipe_tag_q;
  end
`else
  always_comb begin
    acc_vld  = issue;
    acc_data = tab_data_i;
    acc_tag  = tag_k;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= StIdle;
      cnt_q <= '0;
      st_q  <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  // FSM next state.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle:  if (in_valid) fsm_d = StLook;
      StLook:  if (last_look) fsm_d = StDone;
      StDone:  if (out_ready) fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  // Datapath next state.
  always_comb begin
    cnt_d = cnt_q;
    st_d  = st_q;
    acc_d = acc_q;
    res_d = res_q;
    if (fsm_q == StIdle && in_valid) begin
      cnt_d = '0;
      st_d  = state_i;
      acc_d = key_i;
    end
    if (fsm_q == StLook) begin
      if (acc_vld) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          acc_d[32*acc_tag[p][3:2] +: 32] = acc_d[32*acc_tag[p][3:2] +: 32]
                                            ^ rot_e(acc_data[32*p +: 32], acc_tag[p][1:0]);
        end
      end
      cnt_d = last_look ? '0 : cnt_q + CntW'(1);
      if (last_look) res_d = acc_d;
    end
  end

  // Outputs.
  always_comb begin
    in_ready  = (fsm_q == StIdle);
    out_valid = (fsm_q == StDone);
    busy      = (fsm_q != StIdle);
    state_o   = res_q;
    tab_idx_o = '0;
    if (issue) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        tab_idx_o[8*p +: 8] = shift_src(st_q, tag_k[p]);
      end
    end
  end

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: NUM_PORTS=1 and NUM_PORTS=4 instances with a behavioural
// T-table ROM and a textbook AES round model.
module tb_aes_round_seq;

`ifdef AES_ROUND_SEQ_TABREG_EN
  localparam int TabExtra = 1;
`else
  localparam int TabExtra = 0;
`endif
  localparam int Lat1 = 17 + TabExtra;
  localparam int Lat4 = 5 + TabExtra;

  localparam logic [2047:0] SboxFlat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state_in, key_in;
  logic         iv1, ir1, ov1, or1, busy1;
  logic         iv4, ir4, ov4, or4, busy4;
  logic [7:0]   tidx1;
  logic [31:0]  tdat1;
  logic [31:0]  tidx4;
  logic [127:0] tdat4;
  logic [127:0] so1, so4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_round_seq #(.NUM_PORTS(1)) u_dut1 (
    .clk(clk), .reset(rst), .in_valid(iv1), .in_ready(ir1), .state_i(state_in),
    .key_i(key_in), .tab_idx_o(tidx1), .tab_data_i(tdat1), .out_valid(ov1),
    .out_ready(or1), .state_o(so1), .busy(busy1)
  );

  aes_round_seq #(.NUM_PORTS(4)) u_dut4 (
    .clk(clk), .reset(rst), .in_valid(iv4), .in_ready(ir4), .state_i(state_in),
    .key_i(key_in), .tab_idx_o(tidx4), .tab_data_i(tdat4), .out_valid(ov4),
    .out_ready(or4), .state_o(so4), .busy(busy4)
  );

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxFlat[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] te(input logic [7:0] x);
    logic [7:0] s;
    s = sbox(x);
    return {s, s, xt(s), xt(s) ^ s};
  endfunction

  // SubBytes, ShiftRows, MixColumns, AddRoundKey done the textbook way.
  function automatic logic [127:0] aesenc(input logic [127:0] s, input logic [127:0] k);
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        sr[4*c+j] = sbox(s[8*(4*((c+j)%4)+j) +: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      r[32*c    +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[32*c+8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r ^ k;
  endfunction

  always_comb begin
    tdat1 = te(tidx1);
    for (int p = 0; p < 4; p++) tdat4[32*p +: 32] = te(tidx4[8*p +: 8]);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] idx_seen [16];

  // Issue one request and wait for out_valid; the accept edge counts as clock 1.
  task automatic do_round(input bit four, input logic [127:0] s, input logic [127:0] k,
                          input int exp_lat, output logic [127:0] res);
    int n;
    state_in = s;
    key_in   = k;
    chk(four ? "in_ready_before" : "in_ready_before1", four ? ir4 : ir1, 1);
    if (four) iv4 = 1'b1; else iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    iv4 = 1'b0;
    n = 1;
    while (n <= 40) begin
      if (!four && n <= 16) idx_seen[n-1] = tidx1;
      if (four ? ov4 : ov1) break;
      @(posedge clk); #1;
      n++;
    end
    chk(four ? "latency4" : "latency1", n, exp_lat);
    res = four ? so4 : so1;
  endtask

  // Leave DONE with out_ready high: exactly one DONE cycle, then IDLE.
  task automatic leave_done(input bit four);
    @(posedge clk); #1;
    chk("done_one_cycle", four ? ov4 : ov1, 0);
    chk("back_idle", four ? ir4 : ir1, 1);
  endtask

  logic [127:0] res, held, vec;
  int n;
  localparam int Seq [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  initial begin
    rst = 1'b1; iv1 = 1'b0; iv4 = 1'b0; or1 = 1'b1; or4 = 1'b1;
    state_in = '0; key_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ir1, 1);
    chk("rst_out_valid", ov1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_tab_idx", tidx1, 0);
    chk("rst_state_o", so1, 0);
    chk("rst_tab_idx4", tidx4, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_round(0, '0, '0, Lat1, res);
    chk("zero_zero_p1", res, {16{8'h63}});
    leave_done(0);

    do_round(0, '0, {128{1'b1}}, Lat1, res);
    chk("zero_ones_p1", res, {16{8'h9c}});
    leave_done(0);

    do_round(1, '0, {128{1'b1}}, Lat4, res);
    chk("zero_ones_p4", res, {16{8'h9c}});
    leave_done(1);

    do_round(0, {16{8'h52}}, 128'h0f0e0d0c0b0a09080706050403020100, Lat1, res);
    chk("s52_passkey", res, 128'h0f0e0d0c0b0a09080706050403020100);
    leave_done(0);

    vec = 128'h00112233445566778899aabbccddeeff;
    do_round(0, vec, '0, Lat1, res);
    chk("aesenc_vec_p1", res, aesenc(vec, '0));
    chk("tab_idx_done", tidx1, 0);
    leave_done(0);
    for (int k = 0; k < 16; k++) chk($sformatf("tab_idx_k%0d", k), idx_seen[k], vec[8*Seq[k] +: 8]);

    do_round(1, vec, '0, Lat4, res);
    chk("aesenc_vec_p4", res, aesenc(vec, '0));
    leave_done(1);

    // Back-pressure with in_valid pulses while busy.
    or1 = 1'b0;
    state_in = 128'h3243f6a8885a308d313198a2e0370734;
    key_in   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    n = 1;
    while (!ov1 && n < 40) begin
      iv1 = (n == 3 || n == 8);
      @(posedge clk); #1;
      n++;
    end
    iv1 = 1'b0;
    chk("bp_latency", n, Lat1);
    held = so1;
    chk("bp_result", held, aesenc(128'h3243f6a8885a308d313198a2e0370734,
                                  128'h2b7e151628aed2a6abf7158809cf4f3c));
    for (int i = 0; i < 10; i++) begin
      iv1 = i[0];
      @(posedge clk); #1;
      chk("bp_stable", so1, held);
      chk("bp_in_ready", ir1, 0);
    end
    iv1 = 1'b0;
    chk("bp_still_valid", ov1, 1);
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    chk("bp_released", ov1, 0);
    chk("bp_idle", ir1, 1);
    chk("bp_hold_after", so1, held);
    or1 = 1'b1;

    // Reset at LOOK cycle 7, then a fresh request.
    state_in = vec; key_in = {128{1'b1}}; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_look_busy", busy1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_out_valid", ov1, 0);
    chk("mid_rst_state_o", so1, 0);
    do_round(0, 128'h0123456789abcdeffedcba9876543210, 128'h00ff00ff00ff00ff00ff00ff00ff00ff,
             Lat1, res);
    chk("after_rst_result", res, aesenc(128'h0123456789abcdeffedcba9876543210,
                                        128'h00ff00ff00ff00ff00ff00ff00ff00ff));
    leave_done(0);

    // Reset while sitting in DONE.
    or4 = 1'b0;
    do_round(1, vec, {128{1'b1}}, Lat4, res);
    chk("done_rst_pre", res, aesenc(vec, {128{1'b1}}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    or4 = 1'b1;
    chk("done_rst_out_valid", ov4, 0);
    chk("done_rst_in_ready", ir4, 1);
    chk("done_rst_state_o", so4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
